// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-look-ahead adder/subtractor, one register stage per 4-bit group
// A whole-pipe stall (no bubble squeezing) keeps in_ready a single gate away from out_ready.

module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    c3   = c[3];
    cout = c[4];
  end
endmodule

module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero
);
  localparam int L = WIDTH / 4;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  logic             valid_q   [L];
  logic             valid_d   [L];
  logic             carry_q   [L];
  logic             carry_d   [L];
  logic [WIDTH-1:0] sum_q     [L];
  logic [WIDTH-1:0] sum_d     [L];
  logic [WIDTH-1:0] a_rem_q   [L];
  logic [WIDTH-1:0] a_rem_d   [L];
  logic [WIDTH-1:0] b_rem_q   [L];
  logic [WIDTH-1:0] b_rem_d   [L];
  logic             c_msb_q;
  logic             c_msb_d;

  logic [WIDTH-1:0] stg_a      [L];
  logic [WIDTH-1:0] stg_b      [L];
  logic             stg_cin    [L];
  logic [WIDTH-1:0] prev_sum   [L];
  logic             prev_valid [L];
  logic [3:0]       grp_s      [L];
  logic             grp_c3     [L];
  logic             grp_co     [L];
  logic             adv;

  // Remaining operands travel right-shifted so the next group always sits in bits [3:0].
  always_comb begin
    stg_a[0]      = a;
    stg_b[0]      = sub ? ~b : b;
    stg_cin[0]    = sub ? 1'b1 : ci;
    prev_sum[0]   = '0;
    prev_valid[0] = in_valid;
    for (int k = 1; k < L; k++) begin
      stg_a[k]      = a_rem_q[k-1];
      stg_b[k]      = b_rem_q[k-1];
      stg_cin[k]    = carry_q[k-1];
      prev_sum[k]   = sum_q[k-1];
      prev_valid[k] = valid_q[k-1];
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_grp
    cla_group4 u_grp (
      .a    (stg_a[g][3:0]),
      .b    (stg_b[g][3:0]),
      .cin  (stg_cin[g]),
      .s    (grp_s[g]),
      .c3   (grp_c3[g]),
      .cout (grp_co[g])
    );
  end

  always_comb begin
    adv     = !valid_q[L-1] || out_ready;
    c_msb_d = adv ? grp_c3[L-1] : c_msb_q;
    for (int k = 0; k < L; k++) begin
      valid_d[k] = valid_q[k];
      carry_d[k] = carry_q[k];
      sum_d[k]   = sum_q[k];
      a_rem_d[k] = a_rem_q[k];
      b_rem_d[k] = b_rem_q[k];
      if (adv) begin
        valid_d[k] = prev_valid[k];
        carry_d[k] = grp_co[k];
        sum_d[k]   = prev_sum[k] | (WIDTH'(grp_s[k]) << (4 * k));
        a_rem_d[k] = stg_a[k] >> 4;
        b_rem_d[k] = stg_b[k] >> 4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_rem_q[k] <= '0;
        b_rem_q[k] <= '0;
      end
      c_msb_q <= 1'b0;
    end else begin
      for (int k = 0; k < L; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        sum_q[k]   <= sum_d[k];
        a_rem_q[k] <= a_rem_d[k];
        b_rem_q[k] <= b_rem_d[k];
      end
      c_msb_q <= c_msb_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q[L-1];
  assign sum       = sum_q[L-1];
  assign co        = carry_q[L-1];
  assign ovf       = c_msb_q ^ carry_q[L-1];
  assign zero      = (sum_q[L-1] == '0);
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - randomized and directed bench for cla_pipe_adder against an arithmetic model
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
  logic [15:0] a, b, sum;
  logic        iv8, ir8, ci8, sub8, ov8, co8, of8, z8;
  logic [7:0]  a8, b8, s8;
  logic        iv4, ir4, ci4, sub4, ov4, co4, of4, z4;
  logic [3:0]  a4, b4, s4;

  cla_pipe_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .co(co), .ovf(ovf), .zero(zero));
  cla_pipe_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .ci(ci8), .sub(sub8), .out_valid(ov8), .out_ready(1'b1), .sum(s8),
    .co(co8), .ovf(of8), .zero(z8));
  cla_pipe_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .ci(ci4), .sub(sub4), .out_valid(ov4), .out_ready(1'b1), .sum(s4),
    .co(co4), .ovf(of4), .zero(z4));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } res_t;

  res_t q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Integer arithmetic reference: co is the unsigned carry/no-borrow, ovf is signed range overflow.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic cin, input logic sb);
    res_t r;
    int   ux = int'(x);
    int   uy = int'(y);
    int   sx = $signed(x);
    int   sy = $signed(y);
    int   full;
    int   sres;
    if (sb) begin
      full = ux - uy;
      r.co = (ux >= uy);
      sres = sx - sy;
    end else begin
      full = ux + uy + int'(cin);
      r.co = (full > 65535);
      sres = sx + sy + int'(cin);
    end
    r.s   = full[15:0];
    r.ovf = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  logic        mon_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] hold_s;
  logic        hold_co, hold_ovf, hold_z;
  res_t        exp_r;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        check("in_ready_adv", in_ready, !out_valid || out_ready);
        if (prev_stall) begin
          check("stall_valid", out_valid, 1'b1);
          check("stall_sum", sum, hold_s);
          check("stall_co", co, hold_co);
          check("stall_ovf", ovf, hold_ovf);
          check("stall_zero", zero, hold_z);
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got sum %0h with no result expected", sum);
          end else begin
            exp_r = q[0];
            check("mon_sum", sum, exp_r.s);
            check("mon_co", co, exp_r.co);
            check("mon_ovf", ovf, exp_r.ovf);
            check("mon_zero", zero, exp_r.s == 16'h0);
            if (out_ready) void'(q.pop_front());
          end
        end
        if (in_valid && in_ready) q.push_back(model(a, b, ci, sub));
        prev_stall = out_valid && !out_ready;
        hold_s = sum;
        hold_co = co;
        hold_ovf = ovf;
        hold_z = zero;
      end
    end
  end

  task automatic run_dir(input int which, input logic [15:0] x, input logic [15:0] y,
                         input logic cin, input logic sb, input logic [15:0] e_s,
                         input logic e_co, input logic e_ovf, input int e_lat, input string name);
    int          n = 0;
    logic        got = 1'b0;
    logic [15:0] rs = '0;
    logic        rco = 1'b0, rof = 1'b0, rz = 1'b0;
    @(posedge clk); #1;
    case (which)
      16:      begin a = x; b = y; ci = cin; sub = sb; in_valid = 1'b1; end
      8:       begin a8 = x[7:0]; b8 = y[7:0]; ci8 = cin; sub8 = sb; iv8 = 1'b1; end
      default: begin a4 = x[3:0]; b4 = y[3:0]; ci4 = cin; sub4 = sb; iv4 = 1'b1; end
    endcase
    while (!got && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        iv8 = 1'b0;
        iv4 = 1'b0;
      end
      case (which)
        16:      if (out_valid) begin got = 1'b1; rs = sum; rco = co; rof = ovf; rz = zero; end
        8:       if (ov8) begin got = 1'b1; rs = {8'h0, s8}; rco = co8; rof = of8; rz = z8; end
        default: if (ov4) begin got = 1'b1; rs = {12'h0, s4}; rco = co4; rof = of4; rz = z4; end
      endcase
    end
    check({name, ".latency"}, n, e_lat);
    check({name, ".sum"}, rs, e_s);
    check({name, ".co"}, rco, e_co);
    check({name, ".ovf"}, rof, e_ovf);
    check({name, ".zero"}, rz, e_s == 16'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent = 0;
    int   cyc = 0;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0; sub4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0);
    check("rst_co", co, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_zero", zero, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);
    mon_en = 1'b1;

    run_dir(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "add_wrap");
    run_dir(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "add_ovf");
    run_dir(16, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 4, "add_ci");
    run_dir(16, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4, "sub_borrow");
    run_dir(16, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, "sub_ovf");
    run_dir(8, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2, "w8_add");
    run_dir(8, 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1, 2, "w8_sub");
    run_dir(4, 16'h0007, 16'h0001, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b1, 1, "w4_add");
    run_dir(4, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h000E, 1'b0, 1'b0, 1, "w4_sub");

    a = rand_op(); b = rand_op(); ci = 1'($urandom); sub = 1'($urandom);
    while (sent < 32 && cyc < 400) begin
      out_ready = (cyc % 3 != 2);
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        a = rand_op(); b = rand_op(); ci = 1'($urandom); sub = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("random_sent", sent, 32);
    cyc = 0;
    while ((q.size() != 0 || out_valid) && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("random_drained", q.size(), 0);

    for (int i = 0; i < 3; i++) begin
      a = rand_op(); b = rand_op(); ci = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, 16'h0);
    check("midrst_co", co, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_result", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-look-ahead adder/subtractor built from 4-bit CLA groups, with one register stage per group. It replaces the single-shot 4-bit combinational CLA datapath where wider operands and higher clock rates are needed. A valid/ready handshake on input and output provides full backpressure. It also produces carry-out, signed overflow and zero flags.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of 4 and at least 4; elaboration error otherwise.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+ci; 1: a-b, computed as a+~b+1 with ci ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- co  out  1  carry out of the MSB; in subtract mode 1 = no borrow, i.e. a>=b unsigned.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

## Operation
- L = WIDTH/4 stages. Stage k holds a valid bit, the carry out of group k, and sum bits [4k+3:0].
  - It also holds the still-unprocessed operand bits (a, and b already inverted if sub) for groups k+1..L-1.
  - For stage L-1 only, it holds the carry into the MSB (the ovf source).
- Each group computes p=a^b and g=a&b per bit, plus look-ahead carries c1..c4 from the group carry-in.
  - Sum bit i = p[i] ^ c[i].
  - Carry-in of group 0 = sub ? 1 : ci. Carry-in of group k>0 = the stored carry of stage k-1.
- Stage L-1 registers drive sum, co, ovf and out_valid. zero is derived from the registered sum, either registered or combinational from stage L-1.
- Global advance: adv = !out_valid || out_ready.
  - When adv=1, every stage loads from its predecessor, and stage 0 loads from the inputs with valid = in_valid.
  - When adv=0, all stages hold their contents.
- in_ready = adv. in_ready may depend combinationally on out_ready; there is no other combinational input-to-output path.
- Bubbles are not squeezed. The pipe only ever stalls as a whole, which keeps the control path trivial.
- Results leave in acceptance order. Each accepted operand set produces exactly one result.

## Timing
- Reset (rst_n=0 at an edge): all stage valid bits, sum, co and ovf go to 0. zero reads 1 (sum=0) but carries no meaning while out_valid=0.
  - in_ready = 1 from the first cycle after reset.
  - Reset wins over any simultaneous transfer. In-flight operations are discarded, not completed.
- Latency: a set accepted at edge E (in_valid=1 and in_ready=1) shows out_valid=1 with its result after edge E+L-1. That is L edges including E: L=4 for WIDTH=16, L=1 for WIDTH=4.
- Throughput: one operation per cycle while out_ready=1.
- Stall: out_valid=1 and out_ready=0 drives in_ready=0 in the same cycle. sum, co, ovf, zero and out_valid hold stable until the transfer completes.
- Simultaneous accept and drain in one cycle is legal and loses nothing.
- in_valid with in_ready=0: no state change. The upstream must hold a, b, ci and sub.
- Data inputs are don't-care when in_valid=0.

## Test plan
- WIDTH=16, add, a=0xFFFF, b=0x0001, ci=0, out_ready=1, accepted at edge 0 -> out_valid after edge 3; sum=0x0000, co=1, ovf=0, zero=1.
- Add, a=0x7FFF, b=0x0001, ci=0 -> sum=0x8000, co=0, ovf=1, zero=0. Then a=0x1234, b=0x4321, ci=1 -> sum=0x5556, co=0, ovf=0.
- Subtract, a=0x0005, b=0x0007, ci=1 (must be ignored) -> sum=0xFFFE, co=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, co=1, ovf=1.
- 32 back-to-back random ops, out_ready low every third cycle:
  - results match the reference model in order, with no drops or duplicates;
  - in_ready equals adv each cycle;
  - outputs stay stable during every stall.
- Reset mid-flight: 3 ops in the pipe, rst_n=0 for one edge -> out_valid=0, sum=0, co=0, ovf=0 the next cycle, in_ready=1, and none of the 3 results ever appears.
- WIDTH=4 and WIDTH=8 instances: latency 1 and 2 respectively; 8-bit 0xFF+0x01 -> sum 0x00, co=1. A WIDTH=6 instance fails elaboration.
